axis_crossbar: RTL and testbench



---
 rtl/axis_crossbar.sv | 237 +++++++++++++++++++++++
 tb/tb_axis_crossbar.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_crossbar.sv
// axis_crossbar: non-blocking AXI-Stream crossbar. Every slave port feeds its
// own first-word-fall-through FIFO; every master port owns a round-robin
// arbiter, so packets to different destinations flow concurrently. Routing is
// by the tdest of the first beat and stays locked until tlast. Packets whose
// tdest names no master are drained and counted.
//
// Per-slave state:
//   state    | meaning
//   S_IDLE   | head beat (if any) starts a new packet
//   S_LOCKED | packet is being forwarded by exactly one master
//   S_DROP   | packet has an invalid tdest, beats are discarded up to tlast
module axis_crossbar #(
    parameter int PORTS       = 4,
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 8,
    parameter int TUSER_WIDTH = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int FIFO_AWIDTH = 2
) (
    input  logic                         clk,
    input  logic                         resn,
    input  logic [PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [PORTS*TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic [PORTS*TID_WIDTH-1:0]   s_axis_tid,
    input  logic [PORTS-1:0]             s_axis_tvalid,
    input  logic [PORTS-1:0]             s_axis_tlast,
    output logic [PORTS-1:0]             s_axis_tready,
    output logic [PORTS*TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [PORTS*TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [PORTS*TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [PORTS*TID_WIDTH-1:0]   m_axis_tid,
    output logic [PORTS-1:0]             m_axis_tvalid,
    output logic [PORTS-1:0]             m_axis_tlast,
    input  logic [PORTS-1:0]             m_axis_tready,
    output logic [PORTS-1:0]             m_port_busy,
    output logic [15:0]                  drop_count
);

    localparam int DEPTH = 2 ** FIFO_AWIDTH;
    localparam int SW    = $clog2(PORTS);
    localparam int EW    = 1 + TUSER_WIDTH + TDEST_WIDTH + TDATA_WIDTH;
    localparam int CW    = FIFO_AWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_DROP   = 2'd2
    } slv_state_e;

    // FIFO storage, entry = {tlast, tuser, tdest, tdata}
    logic [EW-1:0]          mem       [PORTS][DEPTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr    [PORTS];
    logic [FIFO_AWIDTH-1:0] rd_ptr    [PORTS];
    logic [CW-1:0]          count     [PORTS];
    logic [EW-1:0]          head      [PORTS];
    logic [TDEST_WIDTH-1:0] head_dest [PORTS];

    slv_state_e slv_state     [PORTS];
    slv_state_e slv_state_nxt [PORTS];

    logic [PORTS-1:0] empty, head_last, head_bad, at_start;
    logic [PORTS-1:0] push, pop, drop_pop, drop_start, granted, released;

    logic [PORTS-1:0] busy, grant_valid, hs;
    logic [SW-1:0]    lock_src   [PORTS];
    logic [SW-1:0]    last_grant [PORTS];
    logic [SW-1:0]    grant_src  [PORTS];
    logic [15:0]      drop_nxt;

    // tid on the slave side carries no meaning inside the crossbar
    logic unused_tid;
    assign unused_tid = ^s_axis_tid;

    assign m_port_busy = busy;

    // head decode, slave-side ready and drop detection
    always_comb begin
        for (int s = 0; s < PORTS; s++) begin
            head[s]          = mem[s][rd_ptr[s]];
            head_dest[s]     = head[s][TDATA_WIDTH +: TDEST_WIDTH];
            head_last[s]     = head[s][EW-1];
            empty[s]         = (count[s] == '0);
            head_bad[s]      = int'(head_dest[s]) >= PORTS;
            at_start[s]      = !empty[s] && (slv_state[s] == S_IDLE);
            drop_start[s]    = at_start[s] && head_bad[s];
            drop_pop[s]      = !empty[s] && ((slv_state[s] == S_DROP) || drop_start[s]);
            s_axis_tready[s] = resn && (count[s] < CW'(DEPTH));
            push[s]          = s_axis_tvalid[s] && s_axis_tready[s];
        end
    end

    // per-master round-robin choice among slaves whose packet starts with tdest == j
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < PORTS; j++) begin
            grant_valid[j] = 1'b0;
            grant_src[j]   = '0;
            if (!busy[j]) begin
                for (int k = 1; k <= PORTS; k++) begin
                    idx = (int'(last_grant[j]) + k) % PORTS;
                    if (!grant_valid[j] && at_start[idx] && int'(head_dest[idx]) == j) begin
                        grant_valid[j] = 1'b1;
                        grant_src[j]   = SW'(idx);
                    end
                end
            end
        end
    end

    // master output mux; anything not carrying a valid beat is driven to zero
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tdest  = '0;
        m_axis_tid    = '0;
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (resn && busy[j] && !empty[lock_src[j]]) begin
                m_axis_tvalid[j] = 1'b1;
                m_axis_tlast[j]  = head_last[lock_src[j]];
                m_axis_tdata[j*TDATA_WIDTH +: TDATA_WIDTH] = head[lock_src[j]][0 +: TDATA_WIDTH];
                m_axis_tdest[j*TDEST_WIDTH +: TDEST_WIDTH] = head_dest[lock_src[j]];
                m_axis_tuser[j*TUSER_WIDTH +: TUSER_WIDTH] =
                    head[lock_src[j]][TDATA_WIDTH+TDEST_WIDTH +: TUSER_WIDTH];
                m_axis_tid[j*TID_WIDTH +: TID_WIDTH] = TID_WIDTH'(lock_src[j]);
            end
            hs[j] = m_axis_tvalid[j] && m_axis_tready[j];
        end
    end

    // FIFO pops and lock events gathered back onto the slave side
    always_comb begin
        pop      = drop_pop;
        granted  = '0;
        released = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (hs[j]) begin
                pop[lock_src[j]] = 1'b1;
                if (m_axis_tlast[j]) released[lock_src[j]] = 1'b1;
            end
            if (grant_valid[j]) granted[grant_src[j]] = 1'b1;
        end
    end

    // per-slave next state
    always_comb begin
        for (int s = 0; s < PORTS; s++) begin
            slv_state_nxt[s] = slv_state[s];
            case (slv_state[s])
                S_IDLE: begin
                    if (granted[s])
                        slv_state_nxt[s] = S_LOCKED;
                    else if (drop_start[s] && !head_last[s])
                        slv_state_nxt[s] = S_DROP;
                end
                S_LOCKED: if (released[s]) slv_state_nxt[s] = S_IDLE;
                S_DROP:   if (drop_pop[s] && head_last[s]) slv_state_nxt[s] = S_IDLE;
                default:  slv_state_nxt[s] = S_IDLE;
            endcase
        end
    end

    // saturating drop counter, one increment per dropped packet
    always_comb begin
        drop_nxt = drop_count;
        for (int s = 0; s < PORTS; s++) begin
            if (drop_start[s] && drop_nxt != 16'hFFFF) drop_nxt = drop_nxt + 16'd1;
        end
    end

    // FIFO storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        for (int s = 0; s < PORTS; s++) begin
            if (push[s]) begin
                mem[s][wr_ptr[s]] <= {s_axis_tlast[s],
                                      s_axis_tuser[s*TUSER_WIDTH +: TUSER_WIDTH],
                                      s_axis_tdest[s*TDEST_WIDTH +: TDEST_WIDTH],
                                      s_axis_tdata[s*TDATA_WIDTH +: TDATA_WIDTH]};
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int s = 0; s < PORTS; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < PORTS; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + FIFO_AWIDTH'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + FIFO_AWIDTH'(1);
                count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    // slave state register and drop counter
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int s = 0; s < PORTS; s++) slv_state[s] <= S_IDLE;
            drop_count <= '0;
        end else begin
            for (int s = 0; s < PORTS; s++) slv_state[s] <= slv_state_nxt[s];
            drop_count <= drop_nxt;
        end
    end

    // master lock registers: grant when idle, release on the tlast handshake
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int j = 0; j < PORTS; j++) begin
                busy[j]       <= 1'b0;
                lock_src[j]   <= '0;
                last_grant[j] <= SW'(PORTS - 1);
            end
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                if (busy[j]) begin
                    if (hs[j] && m_axis_tlast[j]) begin
                        busy[j]       <= 1'b0;
                        last_grant[j] <= lock_src[j];
                    end
                end else if (grant_valid[j]) begin
                    busy[j]     <= 1'b1;
                    lock_src[j] <= grant_src[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_crossbar.sv
// Bench for axis_crossbar (PORTS=4, 8-bit fields, 4-deep FIFOs). A per-cycle
// engine drives slave queues and master ready; a packet-level scoreboard
// checks every master beat against per-(source,destination) expectations.
module tb_axis_crossbar;

    localparam int P = 4;

    typedef logic [24:0] beat_t;   // {tlast, tuser, tdest, tdata}
    typedef struct { int cyc; int tid; beat_t b; } cap_t;
    typedef struct { int src; int dest; int len; int base;
                     int exp_beats; int exp_tid; int exp_drop; } vec_t;

    logic clk = 1'b0;
    logic resn = 1'b0;
    logic [P*8-1:0] s_tdata = '0, s_tuser = '0, s_tdest = '0, s_tid = '0;
    logic [P-1:0]   s_tvalid = '0, s_tlast = '0, s_tready;
    logic [P*8-1:0] m_tdata, m_tuser, m_tdest, m_tid;
    logic [P-1:0]   m_tvalid, m_tlast, m_tready = '0, m_busy;
    logic [15:0]    drop_count;

    axis_crossbar dut (
        .clk(clk), .resn(resn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
        .s_axis_tid(s_tid), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest),
        .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready), .m_port_busy(m_busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    beat_t src_q [P][$];
    cap_t  cap_q [P][$];
    int    acc_q [P][$];
    beat_t exp_q [P*P][$];
    bit    in_pkt [P];
    int    pkt_dest [P];
    int    mcur [P];
    int    exp_drops;
    bit    src_rand, rdy_rand;
    logic [P-1:0] m_rdy = '1;
    int    cyc, checks, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input bit last, input int dest, input int data);
        return {last, 8'(data) ^ 8'hA5, 8'(dest), 8'(data)};
    endfunction

    task automatic load_pkt(input int s, input int dest, input int len, input int base);
        for (int i = 0; i < len; i++) src_q[s].push_back(mk(i == len - 1, dest, base + i));
    endtask

    function automatic int pending();
        int p = 0;
        for (int s = 0; s < P; s++) p += src_q[s].size();
        for (int k = 0; k < P*P; k++) p += exp_q[k].size();
        return p;
    endfunction

    task automatic clear_logs();
        for (int k = 0; k < P; k++) begin
            cap_q[k].delete();
            acc_q[k].delete();
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < P; k++) begin
            src_q[k].delete();
            in_pkt[k] = 1'b0;
            mcur[k] = -1;
        end
        for (int k = 0; k < P*P; k++) exp_q[k].delete();
        exp_drops = 0;
    endtask

    // reference: a packet goes wholly to the master named by its first tdest,
    // or is dropped (and counted once) when that tdest is out of range
    task automatic model_accept(input int s, input beat_t b);
        if (!in_pkt[s]) begin
            pkt_dest[s] = int'(b[15:8]);
            if (pkt_dest[s] >= P && exp_drops < 65535) exp_drops++;
        end
        if (pkt_dest[s] < P) exp_q[s*P + pkt_dest[s]].push_back(b);
        in_pkt[s] = !b[24];
        acc_q[s].push_back(cyc);
    endtask

    task automatic model_beat(input int j);
        cap_t  c;
        beat_t b;
        int    t;
        t = int'(m_tid[j*8 +: 8]);
        b = {m_tlast[j], m_tuser[j*8 +: 8], m_tdest[j*8 +: 8], m_tdata[j*8 +: 8]};
        c.cyc = cyc; c.tid = t; c.b = b;
        cap_q[j].push_back(c);
        chk("tid_in_range", 32'(t < P), 1);
        if (t < P) begin
            if (mcur[j] >= 0) chk("no_interleave", t, mcur[j]);
            chk("beat_pending", 32'(exp_q[t*P + j].size() > 0), 1);
            if (exp_q[t*P + j].size() > 0) chk("beat_content", b, exp_q[t*P + j].pop_front());
            mcur[j] = b[24] ? -1 : t;
        end
    endtask

    // one clock: drive at the falling edge, sample 1 ns later, the handshakes
    // recorded here complete on the following rising edge
    task automatic step();
        beat_t b;
        @(negedge clk);
        for (int s = 0; s < P; s++) begin
            if (src_q[s].size() > 0 && (!src_rand || $urandom_range(9, 0) < 7)) begin
                b = src_q[s][0];
                s_tvalid[s] = 1'b1;
                s_tlast[s]  = b[24];
                s_tuser[s*8 +: 8] = b[23:16];
                s_tdest[s*8 +: 8] = b[15:8];
                s_tdata[s*8 +: 8] = b[7:0];
            end else begin
                s_tvalid[s] = 1'b0;
                s_tlast[s]  = 1'b0;
            end
            s_tid[s*8 +: 8] = 8'($urandom);
        end
        m_tready = rdy_rand ? 4'($urandom) : m_rdy;
        #1;
        for (int s = 0; s < P; s++)
            if (s_tvalid[s] && s_tready[s]) model_accept(s, src_q[s].pop_front());
        for (int j = 0; j < P; j++) begin
            if (m_tvalid[j] && m_tready[j]) model_beat(j);
            else if (!m_tvalid[j])
                chk("idle_master_zero", {m_tdata[j*8 +: 8], m_tuser[j*8 +: 8], m_tdest[j*8 +: 8],
                                         m_tid[j*8 +: 8]} | 32'(m_tlast[j]), 0);
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_within_budget", pending(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resn = 1'b0;
        s_tvalid = '0;
        s_tlast = '0;
        model_reset();
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_fields", m_tdata | m_tuser | m_tdest | m_tid | 32'(m_tlast), 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_drop_count", drop_count, 0);
        repeat (2) @(negedge clk);
        resn = 1'b1;
        #1;
        chk("release_s_tready", s_tready, 4'hF);
        chk("release_busy", m_busy, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int e0, d, n;
        checks = 0; errors = 0; cyc = 0;
        src_rand = 1'b0; rdy_rand = 1'b0;
        model_reset();

        vecs[0] = '{0, 2, 4, 'h11, 4, 0, 0};   // single path
        vecs[1] = '{1, 3, 3, 'h21, 3, 1, 0};
        vecs[2] = '{3, 0, 2, 'h31, 2, 3, 0};
        vecs[3] = '{2, 7, 3, 'h41, 0, 0, 1};   // invalid tdest, dropped
        vecs[4] = '{2, 0, 1, 'h51, 1, 2, 0};   // single-beat after the drop
        vecs[5] = '{1, 1, 1, 'h61, 1, 1, 0};

        do_reset();

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            e0 = exp_drops;
            load_pkt(vecs[v].src, vecs[v].dest, vecs[v].len, vecs[v].base);
            run_until_idle(60);
            repeat (4) step();
            for (int j = 0; j < P; j++)
                chk("vec_beat_count", cap_q[j].size(), (j == vecs[v].dest) ? vecs[v].exp_beats : 0);
            d = vecs[v].dest;
            if (vecs[v].exp_beats > 0 && cap_q[d].size() == vecs[v].exp_beats) begin
                chk("vec_latency", cap_q[d][0].cyc - acc_q[vecs[v].src][0], 2);
                for (int i = 0; i < vecs[v].exp_beats; i++) begin
                    chk("vec_data", cap_q[d][i].b[7:0], 8'(vecs[v].base + i));
                    chk("vec_tid", cap_q[d][i].tid, vecs[v].exp_tid);
                    chk("vec_tlast", cap_q[d][i].b[24], 32'(i == vecs[v].exp_beats - 1));
                end
            end
            chk("vec_drop_count", drop_count, 16'(e0 + vecs[v].exp_drop));
        end

        // concurrency: two independent paths stream side by side
        clear_logs();
        load_pkt(0, 1, 8, 'h80);
        load_pkt(3, 2, 8, 'h90);
        run_until_idle(60);
        repeat (3) step();
        chk("conc_count_m1", cap_q[1].size(), 8);
        chk("conc_count_m2", cap_q[2].size(), 8);
        if (cap_q[1].size() == 8 && cap_q[2].size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                chk("conc_rate_m1", cap_q[1][i].cyc - cap_q[1][i-1].cyc, 1);
                chk("conc_rate_m2", cap_q[2][i].cyc - cap_q[2][i-1].cyc, 1);
            end
            chk("conc_same_finish", cap_q[1][7].cyc - cap_q[2][7].cyc, 0);
        end

        // contention: three sources, three rounds, onto master 3
        do_reset();
        clear_logs();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 3; s++) load_pkt(s, 3, 2, 'hA0 + s*16 + r*2);
        run_until_idle(200);
        repeat (3) step();
        chk("cont_count", cap_q[3].size(), 18);
        if (cap_q[3].size() == 18) begin
            for (int i = 0; i < 18; i++) begin
                chk("cont_tid_order", cap_q[3][i].tid, (i / 2) % 3);
                if (i > 0) chk("cont_gap", cap_q[3][i].cyc - cap_q[3][i-1].cyc, (i % 2 == 1) ? 1 : 2);
            end
        end

        // backpressure: master 1 stalled while a 6-beat packet arrives
        clear_logs();
        m_rdy = 4'b1101;
        load_pkt(0, 1, 6, 'hC0);
        repeat (10) step();
        chk("bp_accepted", acc_q[0].size(), 4);
        chk("bp_s_tready_low", s_tready[0], 0);
        chk("bp_no_output", cap_q[1].size(), 0);
        chk("bp_busy", m_busy[1], 1);
        m_rdy = 4'hF;
        run_until_idle(40);
        repeat (3) step();
        chk("bp_count", cap_q[1].size(), 6);
        if (cap_q[1].size() == 6)
            for (int i = 0; i < 6; i++) chk("bp_order", cap_q[1][i].b[7:0], 8'('hC0 + i));

        // reset in the middle of a packet
        clear_logs();
        load_pkt(1, 0, 5, 'hD0);
        n = 0;
        while (acc_q[1].size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("rst_mid_two_accepted", acc_q[1].size(), 2);
        do_reset();
        clear_logs();
        load_pkt(1, 0, 2, 'hE0);
        run_until_idle(40);
        repeat (3) step();
        chk("post_rst_count", cap_q[0].size(), 2);
        if (cap_q[0].size() == 2)
            for (int i = 0; i < 2; i++) begin
                chk("post_rst_data", cap_q[0][i].b[7:0], 8'('hE0 + i));
                chk("post_rst_tid", cap_q[0][i].tid, 1);
            end

        // random traffic against the packet-level reference
        src_rand = 1'b1;
        rdy_rand = 1'b1;
        for (int s = 0; s < P; s++)
            for (int k = 0; k < 10; k++)
                load_pkt(s, $urandom_range(5, 0), $urandom_range(4, 1), $urandom_range(255, 0));
        run_until_idle(3000);
        rdy_rand = 1'b0;
        m_rdy = 4'hF;
        repeat (6) step();
        chk("rand_drop_count", drop_count, 16'(exp_drops));
        chk("rand_all_idle", m_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
